// File: rtl/machine_timer.sv
// Machine timer and software-interrupt source: 64-bit mtime with prescaler, mtimecmp
// comparator and msip bit behind a small 32-bit register bus with one-cycle acknowledge.
module machine_timer #(
    parameter int PRESCALE_WIDTH   = 16,
    parameter int DEFAULT_PRESCALE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_read_request,
    input  logic        bus_write_request,
    input  logic [4:0]  bus_address,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        bus_ack,
    output logic [63:0] mtime,
    output logic        timer_irq,
    output logic        software_irq
);

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_MSIP        = 3'd4;
    localparam logic [2:0] REG_PRESCALE    = 3'd5;

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_RESET = PRESCALE_WIDTH'(DEFAULT_PRESCALE);

    logic [63:0]               mtime_r;
    logic [63:0]               mtimecmp_r;
    logic                      msip_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [PRESCALE_WIDTH-1:0] prescale_count_r;
    logic                      ack_r;
    logic [31:0]               read_data_r;
    logic                      timer_irq_r;

    logic [2:0]                reg_sel_s;
    logic                      write_s;
    logic                      read_s;
    logic                      tick_s;
    logic                      compare_s;
    logic [63:0]               mtime_next_s;
    logic [63:0]               mtimecmp_next_s;
    logic                      msip_next_s;
    logic [PRESCALE_WIDTH-1:0] prescale_next_s;
    logic [PRESCALE_WIDTH-1:0] prescale_count_next_s;
    logic [31:0]               read_data_next_s;
    logic                      unused_addr_s;

    assign reg_sel_s     = bus_address[4:2];
    assign unused_addr_s = ^bus_address[1:0];
    // A simultaneous read and write is treated purely as a write.
    assign write_s       = bus_write_request;
    assign read_s        = bus_read_request & ~bus_write_request;
    assign tick_s        = (prescale_count_r == prescale_r);
    assign compare_s     = (mtime_r >= mtimecmp_r);

    // Next mtime: a bus write to either half wins over a same-cycle tick, so no carry crosses halves.
    always_comb begin
        mtime_next_s = mtime_r;
        if (write_s && (reg_sel_s == REG_MTIME_LO)) begin
            mtime_next_s = {mtime_r[63:32], bus_write_data};
        end else if (write_s && (reg_sel_s == REG_MTIME_HI)) begin
            mtime_next_s = {bus_write_data, mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_next_s = mtime_r + 64'd1;
        end else begin
            mtime_next_s = mtime_r;
        end
    end

    // Next comparator, msip and prescale reload values from bus writes.
    always_comb begin
        mtimecmp_next_s = mtimecmp_r;
        msip_next_s     = msip_r;
        prescale_next_s = prescale_r;
        if (write_s) begin
            case (reg_sel_s)
                REG_MTIMECMP_LO: mtimecmp_next_s = {mtimecmp_r[63:32], bus_write_data};
                REG_MTIMECMP_HI: mtimecmp_next_s = {bus_write_data, mtimecmp_r[31:0]};
                REG_MSIP:        msip_next_s     = bus_write_data[0];
                REG_PRESCALE:    prescale_next_s = bus_write_data[PRESCALE_WIDTH-1:0];
                default: begin
                    mtimecmp_next_s = mtimecmp_r;
                    msip_next_s     = msip_r;
                    prescale_next_s = prescale_r;
                end
            endcase
        end else begin
            mtimecmp_next_s = mtimecmp_r;
            msip_next_s     = msip_r;
            prescale_next_s = prescale_r;
        end
    end

    // Prescale counter: restarts on reload write or when it reaches the reload value.
    always_comb begin
        prescale_count_next_s = prescale_count_r;
        if (write_s && (reg_sel_s == REG_PRESCALE)) begin
            prescale_count_next_s = {PRESCALE_WIDTH{1'b0}};
        end else if (tick_s) begin
            prescale_count_next_s = {PRESCALE_WIDTH{1'b0}};
        end else begin
            prescale_count_next_s = prescale_count_r + PRESCALE_WIDTH'(1);
        end
    end

    // Read mux sampled from pre-update state; zero on any non-read cycle.
    always_comb begin
        read_data_next_s = 32'd0;
        if (read_s) begin
            case (reg_sel_s)
                REG_MTIME_LO:    read_data_next_s = mtime_r[31:0];
                REG_MTIME_HI:    read_data_next_s = mtime_r[63:32];
                REG_MTIMECMP_LO: read_data_next_s = mtimecmp_r[31:0];
                REG_MTIMECMP_HI: read_data_next_s = mtimecmp_r[63:32];
                REG_MSIP:        read_data_next_s = {31'd0, msip_r};
                REG_PRESCALE:    read_data_next_s = 32'(prescale_r);
                default:         read_data_next_s = 32'd0;
            endcase
        end else begin
            read_data_next_s = 32'd0;
        end
    end

    // State and registered bus response; reset drops any pending acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_r          <= 64'd0;
            mtimecmp_r       <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_r           <= 1'b0;
            prescale_r       <= PRESCALE_RESET;
            prescale_count_r <= {PRESCALE_WIDTH{1'b0}};
            ack_r            <= 1'b0;
            read_data_r      <= 32'd0;
            timer_irq_r      <= 1'b0;
        end else begin
            mtime_r          <= mtime_next_s;
            mtimecmp_r       <= mtimecmp_next_s;
            msip_r           <= msip_next_s;
            prescale_r       <= prescale_next_s;
            prescale_count_r <= prescale_count_next_s;
            ack_r            <= bus_read_request | bus_write_request;
            read_data_r      <= read_data_next_s;
            timer_irq_r      <= compare_s;
        end
    end

    assign bus_ack       = ack_r;
    assign bus_read_data = read_data_r;
    assign mtime         = mtime_r;
    assign timer_irq     = timer_irq_r;
    assign software_irq  = msip_r;

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: table of register vectors plus hand sequences for timing corners;
// bus responses are checked by a scoreboard queue keyed on the cycle the ack is due.
module tb_machine_timer;

    logic        clk;
    logic        reset;
    logic        bus_read_request;
    logic        bus_write_request;
    logic [4:0]  bus_address;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_ack;
    logic [63:0] mtime;
    logic        timer_irq;
    logic        software_irq;

    machine_timer #(.PRESCALE_WIDTH(16), .DEFAULT_PRESCALE(0)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus_read_request  (bus_read_request),
        .bus_write_request (bus_write_request),
        .bus_address       (bus_address),
        .bus_write_data    (bus_write_data),
        .bus_read_data     (bus_read_data),
        .bus_ack           (bus_ack),
        .mtime             (mtime),
        .timer_irq         (timer_irq),
        .software_irq      (software_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        int          tag;
    } sb_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[18];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ntag = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop the expected response in the cycle it is due, otherwise expect a quiet bus.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            chk($sformatf("ack#%0d", sb_q[0].tag), {63'd0, bus_ack}, 64'd1);
            chk($sformatf("rdata#%0d", sb_q[0].tag), {32'd0, bus_read_data}, {32'd0, sb_q[0].data});
            void'(sb_q.pop_front());
        end else if (bus_ack !== 1'b0 || bus_read_data !== 32'd0) begin
            chk("idle_ack", {63'd0, bus_ack}, 64'd0);
            chk("idle_rdata", {32'd0, bus_read_data}, 64'd0);
        end
    end

    task automatic req(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [31:0] wd, input logic [31:0] exp);
        bus_read_request  = rd;
        bus_write_request = wr;
        bus_address       = a;
        bus_write_data    = wd;
        sb_q.push_back('{due: cyc + 1, data: exp, tag: ntag});
        ntag++;
        @(posedge clk);
        #1;
        bus_read_request  = 1'b0;
        bus_write_request = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_read_request  = 1'b0;
        bus_write_request = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 5'h0C, 32'h0,        32'hFFFF_FFFF};
        tbl[1]  = '{1'b1, 1'b0, 5'h08, 32'h0,        32'hFFFF_FFFF};
        tbl[2]  = '{1'b1, 1'b0, 5'h10, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, 1'b0, 5'h14, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 1'b0, 5'h18, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 1'b0, 5'h1F, 32'h0,        32'h0};
        tbl[6]  = '{1'b0, 1'b1, 5'h1C, 32'h1234,     32'h0};
        tbl[7]  = '{1'b1, 1'b0, 5'h1C, 32'h0,        32'h0};
        tbl[8]  = '{1'b1, 1'b1, 5'h08, 32'hABCD,     32'h0};
        tbl[9]  = '{1'b1, 1'b0, 5'h09, 32'h0,        32'hABCD};
        tbl[10] = '{1'b0, 1'b1, 5'h08, 32'hFFFF_FFFF, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 5'h14, 32'h0001_2345, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 5'h14, 32'h0,        32'h2345};
        tbl[13] = '{1'b0, 1'b1, 5'h14, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 1'b1, 5'h10, 32'hFFFF_FFFF, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 5'h10, 32'h0,        32'h1};
        tbl[16] = '{1'b0, 1'b1, 5'h10, 32'h0,        32'h0};
        tbl[17] = '{1'b1, 1'b0, 5'h0F, 32'h0,        32'hFFFF_FFFF};

        reset             = 1'b1;
        bus_read_request  = 1'b0;
        bus_write_request = 1'b0;
        bus_address       = 5'd0;
        bus_write_data    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mtime", mtime, 64'd0);
        chk("rst_ack", {63'd0, bus_ack}, 64'd0);
        chk("rst_rdata", {32'd0, bus_read_data}, 64'd0);
        chk("rst_timer_irq", {63'd0, timer_irq}, 64'd0);
        chk("rst_sw_irq", {63'd0, software_irq}, 64'd0);
        reset = 1'b0;

        // Register map vectors, issued back to back.
        for (int i = 0; i < 18; i++) begin
            req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp);
        end
        idle(2);

        // Timer compare: mtime=0, mtimecmp=10.
        req(1'b0, 1'b1, 5'h04, 32'd0, 32'd0);
        req(1'b0, 1'b1, 5'h00, 32'd0, 32'd0);
        req(1'b0, 1'b1, 5'h08, 32'd10, 32'd0);
        req(1'b0, 1'b1, 5'h0C, 32'd0, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (mtime == 64'd10) break;
            idle(1);
        end
        chk("mtime_reaches_10", mtime, 64'd10);
        chk("irq_low_at_10", {63'd0, timer_irq}, 64'd0);
        idle(1);
        chk("irq_rise", {63'd0, timer_irq}, 64'd1);
        chk("mtime_11", mtime, 64'd11);
        req(1'b0, 1'b1, 5'h08, 32'd100, 32'd0);
        chk("irq_still_high", {63'd0, timer_irq}, 64'd1);
        idle(1);
        chk("irq_fall", {63'd0, timer_irq}, 64'd0);

        // Software interrupt.
        req(1'b0, 1'b1, 5'h10, 32'hFFFF_FFFF, 32'd0);
        chk("sw_irq_set", {63'd0, software_irq}, 64'd1);
        req(1'b1, 1'b0, 5'h10, 32'd0, 32'd1);
        req(1'b0, 1'b1, 5'h10, 32'd0, 32'd0);
        chk("sw_irq_clr", {63'd0, software_irq}, 64'd0);

        // Prescale 3: ten ticks across a 40-cycle window.
        req(1'b0, 1'b1, 5'h14, 32'd3, 32'd0);
        req(1'b0, 1'b1, 5'h04, 32'd0, 32'd0);
        req(1'b0, 1'b1, 5'h00, 32'd0, 32'd0);
        req(1'b1, 1'b0, 5'h00, 32'd0, 32'd0);
        idle(39);
        req(1'b1, 1'b0, 5'h00, 32'd0, 32'd10);

        // Carry from low half into high half, then writes racing a tick.
        req(1'b0, 1'b1, 5'h14, 32'd0, 32'd0);
        req(1'b0, 1'b1, 5'h04, 32'd0, 32'd0);
        req(1'b0, 1'b1, 5'h00, 32'hFFFF_FFFF, 32'd0);
        req(1'b1, 1'b0, 5'h00, 32'd0, 32'hFFFF_FFFF);
        chk("carry_mtime", mtime, 64'h0000_0001_0000_0000);
        req(1'b1, 1'b0, 5'h04, 32'd0, 32'd1);
        req(1'b0, 1'b1, 5'h04, 32'd7, 32'd0);
        req(1'b0, 1'b1, 5'h00, 32'hFFFF_FFFF, 32'd0);
        req(1'b1, 1'b0, 5'h04, 32'd0, 32'd7);
        req(1'b1, 1'b0, 5'h00, 32'd0, 32'd0);
        req(1'b0, 1'b1, 5'h00, 32'd5, 32'd0);
        req(1'b1, 1'b0, 5'h00, 32'd0, 32'd5);
        req(1'b1, 1'b0, 5'h08, 32'd0, 32'd100);
        req(1'b1, 1'b0, 5'h18, 32'd0, 32'd0);
        idle(2);
        chk("irq_high_big_mtime", {63'd0, timer_irq}, 64'd1);

        // Reset arriving with a read in flight.
        req(1'b0, 1'b1, 5'h10, 32'd1, 32'd0);
        idle(1);
        bus_read_request = 1'b1;
        bus_address      = 5'h0C;
        reset            = 1'b1;
        @(posedge clk);
        #1;
        bus_read_request = 1'b0;
        reset            = 1'b0;
        chk("midrst_ack", {63'd0, bus_ack}, 64'd0);
        chk("midrst_rdata", {32'd0, bus_read_data}, 64'd0);
        chk("midrst_timer_irq", {63'd0, timer_irq}, 64'd0);
        chk("midrst_sw_irq", {63'd0, software_irq}, 64'd0);
        chk("midrst_mtime", mtime, 64'd0);
        req(1'b1, 1'b0, 5'h0C, 32'd0, 32'hFFFF_FFFF);
        req(1'b1, 1'b0, 5'h10, 32'd0, 32'd0);
        idle(3);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
